br_checkpoint_stack: RTL and testbench

- Consumer end of the branch-mask protocol. Each save holds one architectural recovery checkpoint per branch bit: the map-table snapshot and the free-list head.
- On a save, stores the checkpoint in the one-hot slot that the branch mask controller just allocated.
- On a CORRECT resolution, retires that slot. On a WRONG resolution, returns that slot's snapshot for map-table/free-list recovery and squashes every younger slot.
- Sits beside the branch mask controller, between dispatch/rename and the map table/free list.

---
 rtl/br_checkpoint_stack_pkg.sv | 23 ++
 rtl/br_ckpt_slot.sv | 62 ++++++
 rtl/br_checkpoint_stack.sv | 106 ++++++++++
 tb/tb_br_checkpoint_stack.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/br_checkpoint_stack_pkg.sv
// Shared branch definitions: mask width, resolve states and rename snapshot types.
package br_checkpoint_stack_pkg;

    localparam int BR_MASK_W  = 5;
    localparam int BR_STATE_W = 2;
    localparam int ARCH_REGS  = 32;
    localparam int PRF_IDX_W  = 6;
    localparam int FL_PTR_W   = 5;
    localparam int MAP_W      = ARCH_REGS * PRF_IDX_W;

    typedef enum logic [BR_STATE_W-1:0] {
        BR_PR_NONE    = 2'd0,
        BR_PR_CORRECT = 2'd1,
        BR_PR_WRONG   = 2'd2
    } br_state_e;

    typedef logic [ARCH_REGS-1:0][PRF_IDX_W-1:0] map_snap_t;

    function automatic logic is_onehot(input logic [BR_MASK_W-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/br_ckpt_slot.sv
// One checkpoint slot: live bit, older-slot age mask and the saved rename state.
module br_ckpt_slot
    import br_checkpoint_stack_pkg::*;
#(
    parameter int IDX = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 save_i,
    input  logic [BR_MASK_W-1:0] dep_i,
    input  map_snap_t            map_i,
    input  logic [FL_PTR_W-1:0]  fl_i,
    input  logic [BR_MASK_W-1:0] cor_vec_i,
    input  logic [BR_MASK_W-1:0] wrong_vec_i,
    output logic                 valid_o,
    output map_snap_t            map_o,
    output logic [FL_PTR_W-1:0]  fl_o
);

    logic                 valid_q, valid_d;
    logic [BR_MASK_W-1:0] dep_q, dep_d;
    map_snap_t            map_q, map_d;
    logic [FL_PTR_W-1:0]  fl_q, fl_d;
    logic                 drop;

    // Freed by its own resolution, or squashed because a slot it depends on mispredicted.
    assign drop = cor_vec_i[IDX] | wrong_vec_i[IDX] | (|(dep_q & wrong_vec_i));

    always_comb begin
        valid_d = valid_q;
        dep_d   = dep_q & ~cor_vec_i;
        map_d   = map_q;
        fl_d    = fl_q;
        if (save_i) begin
            valid_d = 1'b1;
            dep_d   = dep_i;
            map_d   = map_i;
            fl_d    = fl_i;
        end else if (drop) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            dep_q   <= '0;
            map_q   <= '0;
            fl_q    <= '0;
        end else begin
            valid_q <= valid_d;
            dep_q   <= dep_d;
            map_q   <= map_d;
            fl_q    <= fl_d;
        end
    end

    assign valid_o = valid_q;
    assign map_o   = map_q;
    assign fl_o    = fl_q;

endmodule

// File: rtl/br_checkpoint_stack.sv
// Per-branch rename checkpoints: saved at dispatch, retired on CORRECT,
// returned for map/free-list recovery on WRONG with younger slots squashed.
module br_checkpoint_stack
    import br_checkpoint_stack_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  save_en_i,
    input  logic [BR_MASK_W-1:0]  save_bit_i,
    input  logic [MAP_W-1:0]      map_snap_i,
    input  logic [FL_PTR_W-1:0]   fl_head_snap_i,
    input  logic [BR_STATE_W-1:0] br_state_i,
    input  logic [BR_MASK_W-1:0]  br_bit_i,
    output logic                  rec_valid_o,
    output logic [MAP_W-1:0]      rec_map_o,
    output logic [FL_PTR_W-1:0]   rec_fl_head_o,
    output logic [BR_MASK_W-1:0]  valid_mask_o,
    output logic                  err_o
);

    logic [BR_MASK_W-1:0] valid_mask;
    logic [BR_MASK_W-1:0] cor_vec, wrong_vec, dep_new;
    logic                 is_cor, is_wr, res_ok, save_go, save_ok;
    logic [MAP_W-1:0]     slot_map [BR_MASK_W];
    logic [FL_PTR_W-1:0]  slot_fl  [BR_MASK_W];
    logic [MAP_W-1:0]     sel_map;
    logic [FL_PTR_W-1:0]  sel_fl;

    logic                 rec_valid_q, rec_valid_d;
    logic [MAP_W-1:0]     rec_map_q, rec_map_d;
    logic [FL_PTR_W-1:0]  rec_fl_q, rec_fl_d;
    logic                 err_q, err_d;

    assign is_cor    = (br_state_i == BR_PR_CORRECT);
    assign is_wr     = (br_state_i == BR_PR_WRONG);
    assign res_ok    = is_onehot(br_bit_i) && (|(br_bit_i & valid_mask));
    assign cor_vec   = (is_cor && res_ok) ? br_bit_i : '0;
    assign wrong_vec = (is_wr && res_ok) ? br_bit_i : '0;

    // A mispredict flushes dispatch, so a same-cycle save is dropped silently.
    assign save_go = save_en_i && !is_wr;
    assign save_ok = is_onehot(save_bit_i)
                     && !(|(save_bit_i & valid_mask & ~cor_vec));
    assign dep_new = valid_mask & ~cor_vec;

    for (genvar k = 0; k < BR_MASK_W; k++) begin : g_slot
        br_ckpt_slot #(.IDX(k)) u_slot (
            .clk         (clk),
            .rst         (rst),
            .save_i      (save_go && save_ok && save_bit_i[k]),
            .dep_i       (dep_new),
            .map_i       (map_snap_i),
            .fl_i        (fl_head_snap_i),
            .cor_vec_i   (cor_vec),
            .wrong_vec_i (wrong_vec),
            .valid_o     (valid_mask[k]),
            .map_o       (slot_map[k]),
            .fl_o        (slot_fl[k])
        );
    end

    always_comb begin
        sel_map = '0;
        sel_fl  = '0;
        for (int k = 0; k < BR_MASK_W; k++) begin
            if (wrong_vec[k]) begin
                sel_map = sel_map | slot_map[k];
                sel_fl  = sel_fl | slot_fl[k];
            end
        end
    end

    always_comb begin
        rec_valid_d = |wrong_vec;
        rec_map_d   = rec_map_q;
        rec_fl_d    = rec_fl_q;
        if (|wrong_vec) begin
            rec_map_d = sel_map;
            rec_fl_d  = sel_fl;
        end
        err_d = err_q
              | ((is_cor || is_wr) && !res_ok)
              | (save_go && !save_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rec_valid_q <= 1'b0;
            rec_map_q   <= '0;
            rec_fl_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            rec_valid_q <= rec_valid_d;
            rec_map_q   <= rec_map_d;
            rec_fl_q    <= rec_fl_d;
            err_q       <= err_d;
        end
    end

    assign rec_valid_o   = rec_valid_q;
    assign rec_map_o     = rec_map_q;
    assign rec_fl_head_o = rec_fl_q;
    assign valid_mask_o  = valid_mask;
    assign err_o         = err_q;

endmodule

// File: tb/tb_br_checkpoint_stack.sv
// Directed scenarios plus a randomized run against an age-ordered checkpoint model.
module tb_br_checkpoint_stack;

    localparam logic [1:0] S_NONE = 2'd0;
    localparam logic [1:0] S_COR  = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;

    logic         clk = 1'b0;
    logic         rst;
    logic         se;
    logic [4:0]   sb;
    logic [191:0] map;
    logic [4:0]   fl;
    logic [1:0]   st;
    logic [4:0]   bb;
    logic         rv;
    logic [191:0] rmap;
    logic [4:0]   rfl;
    logic [4:0]   vm;
    logic         err;

    int n_cmp = 0;
    int n_bad = 0;

    br_checkpoint_stack dut (
        .clk            (clk),
        .rst            (rst),
        .save_en_i      (se),
        .save_bit_i     (sb),
        .map_snap_i     (map),
        .fl_head_snap_i (fl),
        .br_state_i     (st),
        .br_bit_i       (bb),
        .rec_valid_o    (rv),
        .rec_map_o      (rmap),
        .rec_fl_head_o  (rfl),
        .valid_mask_o   (vm),
        .err_o          (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0;
        se  = 1'b0;
        sb  = '0;
        st  = S_NONE;
        bb  = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic drv_save(input int b, input logic [4:0] f, input logic [191:0] m);
        se  = 1'b1;
        sb  = 5'(1 << b);
        fl  = f;
        map = m;
    endtask

    task automatic drv_res(input logic [1:0] s, input int b);
        st = s;
        bb = 5'(1 << b);
    endtask

    task automatic test_reset();
        idle();
        map = '1;
        fl  = '1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (vm !== 5'b0) begin n_bad++; $display("FAIL reset_mask: got %b want 00000", vm); end
        n_cmp++; if (rv !== 1'b0) begin n_bad++; $display("FAIL reset_rv: got %b want 0", rv); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
        n_cmp++; if (rfl !== 5'd0) begin n_bad++; $display("FAIL reset_fl: got %0d want 0", rfl); end
        n_cmp++; if (rmap !== 192'd0) begin n_bad++; $display("FAIL reset_map: got %h want 0", rmap); end
    endtask

    task automatic test_basic_wrong();
        do_reset();
        drv_save(0, 5'd3, 192'd7 << 6);
        tick();
        idle();
        drv_res(S_WR, 0);
        tick();
        idle();
        n_cmp++; if (rv !== 1'b1) begin n_bad++; $display("FAIL basic_rv: got %b want 1", rv); end
        n_cmp++; if (rfl !== 5'd3) begin n_bad++; $display("FAIL basic_fl: got %0d want 3", rfl); end
        n_cmp++; if (rmap[11:6] !== 6'd7) begin n_bad++; $display("FAIL basic_map1: got %0d want 7", rmap[11:6]); end
        n_cmp++; if (vm !== 5'b0) begin n_bad++; $display("FAIL basic_mask: got %b want 00000", vm); end
        tick();
        n_cmp++; if (rv !== 1'b0) begin n_bad++; $display("FAIL basic_pulse: got %b want 0", rv); end
        n_cmp++; if (rfl !== 5'd3) begin n_bad++; $display("FAIL basic_hold: got %0d want 3", rfl); end
    endtask

    task automatic test_nested_wrong();
        logic [191:0] m0, m1;
        m0 = {6{32'hA5A5_0000}};
        m1 = {6{32'h1234_5678}};
        do_reset();
        drv_save(0, 5'd10, m0); tick();
        drv_save(1, 5'd11, m1); tick();
        drv_save(2, 5'd12, ~m0); tick();
        idle();
        drv_res(S_WR, 1);
        tick();
        idle();
        n_cmp++; if (vm !== 5'b00001) begin n_bad++; $display("FAIL nested_mask: got %b want 00001", vm); end
        n_cmp++; if (rfl !== 5'd11) begin n_bad++; $display("FAIL nested_fl: got %0d want 11", rfl); end
        n_cmp++; if (rmap !== m1) begin n_bad++; $display("FAIL nested_map: got %h want %h", rmap, m1); end
        drv_res(S_WR, 0);
        tick();
        idle();
        n_cmp++; if (rfl !== 5'd10) begin n_bad++; $display("FAIL nested_slot0_fl: got %0d want 10", rfl); end
        n_cmp++; if (rmap !== m0) begin n_bad++; $display("FAIL nested_slot0_map: got %h want %h", rmap, m0); end
        n_cmp++; if (vm !== 5'b0) begin n_bad++; $display("FAIL nested_empty: got %b want 00000", vm); end
    endtask

    task automatic test_correct_dep();
        do_reset();
        drv_save(0, 5'd1, '0); tick();
        drv_save(1, 5'd2, '0); tick();
        idle();
        drv_res(S_COR, 0);
        tick();
        idle();
        n_cmp++; if (vm !== 5'b00010) begin n_bad++; $display("FAIL cor_mask: got %b want 00010", vm); end
        n_cmp++; if (rv !== 1'b0) begin n_bad++; $display("FAIL cor_rv: got %b want 0", rv); end
        drv_save(0, 5'd4, '1); tick();
        idle();
        n_cmp++; if (vm !== 5'b00011) begin n_bad++; $display("FAIL cor_resave: got %b want 00011", vm); end
        drv_res(S_WR, 0);
        tick();
        idle();
        n_cmp++; if (vm !== 5'b00010) begin n_bad++; $display("FAIL cor_dep_clear: got %b want 00010", vm); end
        n_cmp++; if (rfl !== 5'd4) begin n_bad++; $display("FAIL cor_rec_fl: got %0d want 4", rfl); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL cor_err: got %b want 0", err); end
    endtask

    task automatic test_full_reuse();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drv_save(i, 5'(20 + i), '0);
            tick();
        end
        idle();
        n_cmp++; if (vm !== 5'b11111) begin n_bad++; $display("FAIL full_mask: got %b want 11111", vm); end
        drv_save(2, 5'd9, {6{32'hCAFE_F00D}});
        drv_res(S_COR, 2);
        tick();
        idle();
        n_cmp++; if (vm !== 5'b11111) begin n_bad++; $display("FAIL reuse_mask: got %b want 11111", vm); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reuse_err: got %b want 0", err); end
        drv_res(S_COR, 4); tick(); idle();
        drv_save(4, 5'd30, '0); tick(); idle();
        drv_res(S_WR, 2);
        tick();
        idle();
        n_cmp++; if (rfl !== 5'd9) begin n_bad++; $display("FAIL reuse_fl: got %0d want 9", rfl); end
        n_cmp++; if (rmap !== {6{32'hCAFE_F00D}}) begin n_bad++; $display("FAIL reuse_map: got %h", rmap); end
        n_cmp++; if (vm !== 5'b01011) begin n_bad++; $display("FAIL reuse_squash: got %b want 01011", vm); end
    endtask

    task automatic test_errors();
        do_reset();
        drv_save(0, 5'd5, '0); tick(); idle();
        drv_save(1, 5'd6, '0);
        drv_res(S_WR, 0);
        tick();
        idle();
        n_cmp++; if (vm !== 5'b0) begin n_bad++; $display("FAIL flush_mask: got %b want 00000", vm); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL flush_err: got %b want 0", err); end
        n_cmp++; if (rv !== 1'b1 || rfl !== 5'd5) begin n_bad++; $display("FAIL flush_rec: got rv=%b fl=%0d want rv=1 fl=5", rv, rfl); end
        drv_save(1, 5'd6, '0); tick();
        drv_save(1, 5'd7, '1); tick(); idle();
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL occupied_err: got %b want 1", err); end
        drv_res(S_WR, 1); tick(); idle();
        n_cmp++; if (rfl !== 5'd6 || rmap !== 192'd0) begin n_bad++; $display("FAIL occupied_data: got fl=%0d want 6", rfl); end
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", err); end
        do_reset();
        drv_res(S_COR, 3); tick(); idle();
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL invalid_cor_err: got %b want 1", err); end
        do_reset();
        se = 1'b1; sb = 5'b00110; tick(); idle();
        n_cmp++; if (err !== 1'b1 || vm !== 5'b0) begin n_bad++; $display("FAIL onehot_err: got err=%b mask=%b want 1/00000", err, vm); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drv_save(0, 5'd1, '0); tick();
        drv_save(1, 5'd2, '0); tick(); idle();
        drv_res(S_WR, 1); tick(); idle();
        n_cmp++; if (rv !== 1'b1 || rfl !== 5'd2) begin n_bad++; $display("FAIL b2b_first: got rv=%b fl=%0d want 1/2", rv, rfl); end
        drv_res(S_WR, 0); tick(); idle();
        n_cmp++; if (rv !== 1'b1 || rfl !== 5'd1) begin n_bad++; $display("FAIL b2b_second: got rv=%b fl=%0d want 1/1", rv, rfl); end
        tick();
        n_cmp++; if (rv !== 1'b0 || rfl !== 5'd1) begin n_bad++; $display("FAIL b2b_end: got rv=%b fl=%0d want 0/1", rv, rfl); end
    endtask

    task automatic test_reset_wrong();
        do_reset();
        drv_save(3, 5'd8, '1); tick(); idle();
        drv_res(S_WR, 3);
        rst = 1'b1;
        tick();
        idle();
        n_cmp++; if (rv !== 1'b0) begin n_bad++; $display("FAIL rstwr_rv: got %b want 0", rv); end
        n_cmp++; if (vm !== 5'b0 || rfl !== 5'd0 || rmap !== 192'd0 || err !== 1'b0) begin
            n_bad++; $display("FAIL rstwr_outs: got mask=%b fl=%0d err=%b want zeros", vm, rfl, err);
        end
    endtask

    task automatic test_random();
        bit           mv[5];
        bit           nv[5];
        int           seq[5];
        logic [191:0] mm[5];
        logic [4:0]   mf[5];
        int           ctr, k, s, r;
        bit           ok, cor_ok, e_rv, e_err;
        logic [191:0] e_map;
        logic [4:0]   e_fl, e_vm;
        int           q[$];

        do_reset();
        for (int i = 0; i < 5; i++) begin
            mv[i] = 0; seq[i] = 0; mm[i] = '0; mf[i] = '0;
        end
        ctr = 0; e_rv = 0; e_err = 0; e_map = '0; e_fl = '0;

        for (int c = 0; c < 3000; c++) begin
            rst = (c % 250 == 0) || ($urandom_range(0, 199) == 0);
            se  = 1'($urandom_range(0, 1));
            q.delete();
            for (int i = 0; i < 5; i++) if (!mv[i]) q.push_back(i);
            if ($urandom_range(0, 19) == 0) sb = 5'($urandom);
            else if (q.size() > 0 && $urandom_range(0, 9) != 0)
                sb = 5'(1 << q[$urandom_range(0, q.size() - 1)]);
            else sb = 5'(1 << $urandom_range(0, 4));
            fl  = 5'($urandom);
            map = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            r = $urandom_range(0, 9);
            st = (r < 5) ? S_NONE : (r < 8) ? S_COR : S_WR;
            q.delete();
            for (int i = 0; i < 5; i++) if (mv[i]) q.push_back(i);
            if ($urandom_range(0, 19) == 0) bb = 5'($urandom);
            else if (q.size() > 0 && $urandom_range(0, 9) != 0)
                bb = 5'(1 << q[$urandom_range(0, q.size() - 1)]);
            else bb = 5'(1 << $urandom_range(0, 4));

            if (rst) begin
                for (int i = 0; i < 5; i++) mv[i] = 0;
                e_rv = 0; e_err = 0; e_map = '0; e_fl = '0;
            end else begin
                nv = mv;
                e_rv = 0;
                k = -1;
                if ($onehot(bb)) for (int i = 0; i < 5; i++) if (bb[i]) k = i;
                ok = (k >= 0) && mv[k];
                if ((st == S_COR || st == S_WR) && !ok) e_err = 1;
                cor_ok = (st == S_COR) && ok;
                if (cor_ok) nv[k] = 0;
                if (st == S_WR && ok) begin
                    e_rv = 1; e_map = mm[k]; e_fl = mf[k]; nv[k] = 0;
                    for (int j = 0; j < 5; j++) if (mv[j] && seq[j] > seq[k]) nv[j] = 0;
                end
                if (se && st != S_WR) begin
                    if (!$onehot(sb)) e_err = 1;
                    else begin
                        s = 0;
                        for (int i = 0; i < 5; i++) if (sb[i]) s = i;
                        if (mv[s] && !(cor_ok && k == s)) e_err = 1;
                        else begin
                            nv[s] = 1; ctr++; seq[s] = ctr; mm[s] = map; mf[s] = fl;
                        end
                    end
                end
                mv = nv;
            end
            for (int i = 0; i < 5; i++) e_vm[i] = mv[i];

            tick();
            n_cmp++; if (vm !== e_vm) begin n_bad++; $display("FAIL rnd_mask c=%0d: got %b want %b", c, vm, e_vm); end
            n_cmp++; if (rv !== e_rv) begin n_bad++; $display("FAIL rnd_rv c=%0d: got %b want %b", c, rv, e_rv); end
            n_cmp++; if (err !== e_err) begin n_bad++; $display("FAIL rnd_err c=%0d: got %b want %b", c, err, e_err); end
            n_cmp++; if (rfl !== e_fl) begin n_bad++; $display("FAIL rnd_fl c=%0d: got %0d want %0d", c, rfl, e_fl); end
            n_cmp++; if (rmap !== e_map) begin n_bad++; $display("FAIL rnd_map c=%0d: got %h want %h", c, rmap, e_map); end
        end
        idle();
    endtask

    initial begin
        idle();
        map = '0;
        fl  = '0;
        test_reset();
        test_basic_wrong();
        test_nested_wrong();
        test_correct_dep();
        test_full_reuse();
        test_errors();
        test_back_to_back();
        test_reset_wrong();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
